// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload bus between two pipeline stages.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer,
// a synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  inBus,
  pipe_stage_reg_if.master outBus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stallCnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stageState_t;

  stageState_t       state;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              inReadyReg;
  logic              inReady;
  logic              inXfer;

  // With the skid buffer, ready is a flop. Without it, ready looks through to downstream.
  generate
    if (SKID != 0) begin : gSkid
      assign inReady = inReadyReg;
    end else begin : gNoSkid
      assign inReady = (state == EMPTY) || outBus.ready;
    end
  endgenerate

  assign inXfer       = inBus.valid && inReady;
  assign inBus.ready  = inReady;
  assign outBus.valid = (state != EMPTY);
  assign outBus.ctrl  = (state != EMPTY) ? mainCtrl : '0;
  assign outBus.data  = mainData;
  assign occupancy    = (state == FULL) ? 2'd2 : ((state == BUSY) ? 2'd1 : 2'd0);

  // FULL can only be entered when an input is accepted while downstream stalls.
  // Without a skid buffer, accepting in BUSY implies out ready, so FULL stays unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      mainCtrl   <= '0;
      mainData   <= '0;
      skidCtrl   <= '0;
      skidData   <= '0;
      inReadyReg <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      inReadyReg <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            state    <= BUSY;
            mainCtrl <= inBus.ctrl;
            mainData <= inBus.data;
          end
        end
        BUSY: begin
          if (inXfer && outBus.ready) begin
            mainCtrl <= inBus.ctrl;
            mainData <= inBus.data;
          end else if (inXfer) begin
            state      <= FULL;
            skidCtrl   <= inBus.ctrl;
            skidData   <= inBus.data;
            inReadyReg <= 1'b0;
          end else if (outBus.ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (outBus.ready) begin
            state      <= BUSY;
            mainCtrl   <= skidCtrl;
            mainData   <= skidData;
            inReadyReg <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          inReadyReg <= 1'b1;
        end
      endcase
    end
  end

  // Stall counter survives flush so that stalls lost to mispredicts still show up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if ((state != EMPTY) && !outBus.ready && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two stages (skid with 4-bit counter, no skid with 16-bit counter)
// share one stimulus stream, and each stage is checked against its own queue model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic [7:0]  inCtrl = '0;
  logic [63:0] inData = '0;
  logic        outReady = 1'b0;

  logic [1:0]  occA, occB;
  logic [3:0]  stallA;
  logic [15:0] stallB;

  int checks = 0;
  int errors = 0;

  logic [71:0] qA[$];
  logic [71:0] qB[$];
  int          expStallA = 0;
  int          expStallB = 0;
  logic        expReadyA = 1'b0;
  logic        expReadyB = 1'b0;

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) inA ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) outA ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) inB ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) outB ();

  assign inA.valid  = inValid;
  assign inA.ctrl   = inCtrl;
  assign inA.data   = inData;
  assign outA.ready = outReady;
  assign inB.valid  = inValid;
  assign inB.ctrl   = inCtrl;
  assign inB.data   = inData;
  assign outB.ready = outReady;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .SKID(1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .flush(flush),
    .inBus(inA), .outBus(outA),
    .occupancy(occA), .stallCnt(stallA)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .SKID(0), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .flush(flush),
    .inBus(inB), .outBus(outB),
    .occupancy(occB), .stallCnt(stallB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; the model records what the stage accepts at the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] c, input logic [63:0] d,
                               input logic r, input logic f);
    inValid  = v;
    inCtrl   = c;
    inData   = d;
    outReady = r;
    flush    = f;
    @(posedge clk);
    if (f) begin
      qA.delete();
      qB.delete();
    end else begin
      if (v && expReadyA) qA.push_back({c, d});
      if (v && expReadyB) qB.push_back({c, d});
    end
    #1;
  endtask

  // Monitor for the skid stage: the model holds what is pending, in acceptance order.
  always @(negedge clk) begin
    if (rst) begin
      expReadyA = 1'b0;
    end else begin
      expReadyA = (qA.size() < 2);
      checkOutput("A.outValid", {63'd0, outA.valid}, {63'd0, qA.size() > 0});
      checkOutput("A.occupancy", {62'd0, occA}, 64'(qA.size()));
      checkOutput("A.inReady", {63'd0, inA.ready}, {63'd0, expReadyA});
      checkOutput("A.stallCnt", {60'd0, stallA}, 64'(expStallA));
      if (qA.size() > 0) begin
        checkOutput("A.outCtrl", {56'd0, outA.ctrl}, {56'd0, qA[0][71:64]});
        checkOutput("A.outData", outA.data, qA[0][63:0]);
      end else begin
        checkOutput("A.bubbleCtrl", {56'd0, outA.ctrl}, 64'd0);
      end
      if (qA.size() > 0 && !outReady && expStallA < 15) expStallA++;
      if (!flush && outReady && qA.size() > 0) void'(qA.pop_front());
    end
  end

  // Monitor for the single-entry stage.
  always @(negedge clk) begin
    if (rst) begin
      expReadyB = 1'b0;
    end else begin
      expReadyB = (qB.size() == 0) || outReady;
      checkOutput("B.outValid", {63'd0, outB.valid}, {63'd0, qB.size() > 0});
      checkOutput("B.occupancy", {62'd0, occB}, 64'(qB.size()));
      checkOutput("B.inReady", {63'd0, inB.ready}, {63'd0, expReadyB});
      checkOutput("B.stallCnt", {48'd0, stallB}, 64'(expStallB));
      if (qB.size() > 0) begin
        checkOutput("B.outCtrl", {56'd0, outB.ctrl}, {56'd0, qB[0][71:64]});
        checkOutput("B.outData", outB.data, qB[0][63:0]);
      end else begin
        checkOutput("B.bubbleCtrl", {56'd0, outB.ctrl}, 64'd0);
      end
      if (qB.size() > 0 && !outReady && expStallB < 65535) expStallB++;
      if (!flush && outReady && qB.size() > 0) void'(qB.pop_front());
    end
  end

  // Reset lands between edges; outputs must clear without waiting for a clock.
  task automatic resetMidCycle();
    #2;
    rst = 1'b1;
    inValid = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("rst.A.outValid", {63'd0, outA.valid}, 64'd0);
    checkOutput("rst.A.outCtrl", {56'd0, outA.ctrl}, 64'd0);
    checkOutput("rst.A.outData", outA.data, 64'd0);
    checkOutput("rst.A.occupancy", {62'd0, occA}, 64'd0);
    checkOutput("rst.A.stallCnt", {60'd0, stallA}, 64'd0);
    checkOutput("rst.B.outValid", {63'd0, outB.valid}, 64'd0);
    checkOutput("rst.B.occupancy", {62'd0, occB}, 64'd0);
    checkOutput("rst.B.stallCnt", {48'd0, stallB}, 64'd0);
    qA.delete();
    qB.delete();
    expStallA = 0;
    expStallB = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst.A.inReadyAfter", {63'd0, inA.ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    #23;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate: one-cycle latency, a single entry in flight.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'hA5, 64'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

    // Fill the skid buffer under stall, then release it.
    applyStimulus(1'b1, 8'h11, 64'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 64'd8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

    // Flush while full with a new offer that must be discarded.
    applyStimulus(1'b1, 8'h33, 64'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 64'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 64'd9, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

    // Asynchronous reset while the skid stage is full.
    applyStimulus(1'b1, 8'h66, 64'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 64'd11, 1'b0, 1'b0);
    resetMidCycle();

    // Long stall: the 4-bit counter must stop at 15.
    applyStimulus(1'b1, 8'h3C, 64'd5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 64'd0, 1'b0, 1'b0);
    checkOutput("sat.A.stallCnt", {60'd0, stallA}, 64'd15);
    applyStimulus(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

    // Random payloads with toggling downstream ready and occasional flushes.
    for (int i = 0; i < 160; i++) begin
      applyStimulus(($urandom_range(0, 5) != 0), 8'($urandom), {$urandom, $urandom},
                    ((i % 2) == 0) ^ ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
